romload_sdram_writer: RTL and testbench
=======================================

// Module: romload_sdram_writer
// PURPOSE
//  Consumes the byte stream produced by the IO subsystem's ROM-loading port (mode, byte, strobe)
//  and writes it into SDRAM through a 16-bit req/ack write port. Pairs bytes little-endian,
//  places each load mode at its own base address, and buffers words in a FIFO (upstream cannot stall).
//  Config-mode bytes go to a register, not memory. Sits between iosys and the SDRAM arbiter.
// PARAMETERS
//  ADDR_W        25         byte-address width of the SDRAM window (32MB)
//  ROM_BASE      25'h0      byte base for mode 1 (cart ROM)
//  CARTRAM_BASE  25'h1E00000 byte base for mode 2 (cart RAM image)
//  BIOS_BASE     25'h1F00000 byte base for mode 4 (BIOS)
//  FIFO_DEPTH    8          word entries, power of two, >=4
// PORTS
//  clk           in   1         system clock, single domain
//  reset         in   1         synchronous, active-high
//  loading       in   3         0 idle, 1 ROM, 2 cart RAM, 3 config, 4 BIOS; others = idle
//  din           in   8         stream byte
//  din_valid     in   1         1-cycle strobe per byte; back-to-back allowed, no backpressure
//  mem_req       out  1         write request, level
//  mem_addr      out  ADDR_W-1  halfword address
//  mem_din       out  16        write data, first byte in [7:0]
//  mem_be        out  2         byte enables ([0] low byte)
//  mem_ack       in   1         1-cycle pulse: current write accepted
//  cfg_data      out  32        config-mode bytes, first byte in [7:0]
//  loaded_bytes  out  ADDR_W    bytes accepted in current/last session
//  busy          out  1         session active or FIFO/write pending
//  done          out  1         1-cycle pulse when a memory session fully drains
//  overflow      out  1         sticky: word dropped due to full FIFO
// BEHAVIOUR
//  - Reset: all outputs 0; FIFO emptied; any in-flight mem_req abandoned (arbiter must tolerate).
//  - Session start: loading goes 0->nonzero, or nonzero->different nonzero. Sets byte pointer to
//    mode base, loaded_bytes=0, overflow=0, clears pending half-word. Mode 3 also clears cfg_data.
//  - Prior-session FIFO entries still drain; each entry carries its own address/be.
//  - Modes 1/2/4, per din_valid: even pointer -> hold byte as low half; odd pointer -> push
//    {addr, {din,low}, be=2'b11}. Pointer and loaded_bytes +1, wrap modulo 2^ADDR_W silently.
//  - Mode 3: cfg_data <= {din, cfg_data[31:8]}; loaded_bytes +1; no memory traffic.
//  - Session end (loading->0 or mode change) with held low byte: push {addr,{8'h00,low},2'b01}
//    on that same cycle. If din_valid coincides with the mode change, the byte is taken under the
//    old mode before the new session begins.
//  - FIFO full on push: entry dropped, overflow<=1; pointer still advances (later addresses correct).
//  - Write port: mem_req=1 whenever FIFO non-empty; addr/din/be = FIFO head, stable until mem_ack.
//    On mem_ack head pops; next entry presented the following cycle with req held (no idle cycle).
//    Push and pop in the same cycle when full: pop frees slot first, push succeeds.
//  - busy = (loading!=0) | FIFO non-empty. done pulses on the cycle busy falls, memory modes only.
//  - Throughput: one byte/clk in; FIFO must absorb a 4-byte burst (2 words) with mem_ack latency<=8.
// STRUCTURE
//  - Package romload_pkg: LOAD_IDLE/ROM/CARTRAM/CONFIG/BIOS mode constants, fifo entry struct
//    {addr, data[15:0], be[1:0]}, function mode_base(mode).
//  - One sub-module: sync_fifo (param WIDTH, DEPTH; push/pop/full/empty, first-word-fall-through).
//  - Top: session/mode FSM (IDLE, STREAM_MEM, STREAM_CFG), byte pairer, address counter.
// TESTING
//  1 Mode 1, bytes 11 22 33 44, ack 3 cycles after req -> writes @0:2211 be=11, @1:4433; done once; loaded_bytes=4.
//  2 Mode 4, bytes AA BB CC then loading->0 -> @F80000:BBAA be=11, @F80001:00CC be=01; done pulse.
//  3 Mode 3, bytes 01 02 03 04 05 -> cfg_data=05040302, mem_req never high, no done.
//  4 Mode 1, 40 back-to-back bytes, mem_ack withheld -> FIFO fills at 8 words, overflow=1,
//    release ack -> 8 writes at addrs 0..7 only; next session clears overflow.
//  5 Mode 1 -> mode 2 change while FIFO holds 3 words -> old words drain at ROM addrs, new at F00000.
//  6 reset asserted mid-write with req high -> next cycle mem_req=0, busy=0, loaded_bytes=0.

Source files
------------

// File: rtl/romload_sdram_writer_pkg.sv
// Shared types for the ROM-load SDRAM writer: load-mode encoding, FIFO entry
// layout and the per-mode byte base address lookup.
package romload_pkg;

    typedef enum logic [2:0] {
        LOAD_IDLE    = 3'd0,
        LOAD_ROM     = 3'd1,
        LOAD_CARTRAM = 3'd2,
        LOAD_CONFIG  = 3'd3,
        LOAD_BIOS    = 3'd4
    } load_mode_e;

    localparam int unsigned ENTRY_ADDR_W = 32;

    typedef struct packed {
        logic [ENTRY_ADDR_W-1:0] addr;
        logic [15:0]             data;
        logic [1:0]              be;
    } fifo_entry_t;

    // Undefined loading codes behave as idle.
    function automatic load_mode_e decode_mode(input logic [2:0] loading);
        case (loading)
            3'd1:    return LOAD_ROM;
            3'd2:    return LOAD_CARTRAM;
            3'd3:    return LOAD_CONFIG;
            3'd4:    return LOAD_BIOS;
            default: return LOAD_IDLE;
        endcase
    endfunction

    function automatic logic [31:0] mode_base(input load_mode_e mode,
                                              input logic [31:0] rom_base,
                                              input logic [31:0] cartram_base,
                                              input logic [31:0] bios_base);
        case (mode)
            LOAD_ROM:     return rom_base;
            LOAD_CARTRAM: return cartram_base;
            LOAD_BIOS:    return bios_base;
            default:      return '0;
        endcase
    endfunction

endpackage

// File: rtl/romload_sdram_writer_fifo.sv
// Synchronous first-word-fall-through FIFO; a pop in the same cycle frees a
// slot for a push even when full.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/romload_sdram_writer.sv
// Turns the iosys ROM-load byte stream into 16-bit SDRAM writes (little-endian
// byte pairs at per-mode bases), with config-mode bytes shifted into cfg_data.
module romload_sdram_writer
    import romload_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 25,
    parameter logic [ADDR_W-1:0] ROM_BASE     = '0,
    parameter logic [ADDR_W-1:0] CARTRAM_BASE = 25'h1E00000,
    parameter logic [ADDR_W-1:0] BIOS_BASE    = 25'h1F00000,
    parameter int unsigned       FIFO_DEPTH   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        loading,
    input  logic [7:0]        din,
    input  logic              din_valid,
    output logic              mem_req,
    output logic [ADDR_W-2:0] mem_addr,
    output logic [15:0]       mem_din,
    output logic [1:0]        mem_be,
    input  logic              mem_ack,
    output logic [31:0]       cfg_data,
    output logic [ADDR_W-1:0] loaded_bytes,
    output logic              busy,
    output logic              done,
    output logic              overflow
);
    typedef enum logic [1:0] {IDLE, STREAM_MEM, STREAM_CFG} state_e;

    state_e      state;
    load_mode_e  cur_mode;
    load_mode_e  new_mode;
    logic [ADDR_W-1:0] ptr;
    logic [7:0]  low;
    logic        busy_q;
    logic        mem_pend;
    logic        session_change;
    logic        mem_byte;
    logic        cfg_byte;
    logic        push;
    fifo_entry_t push_entry;
    fifo_entry_t head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic [31:0] base_full;
    logic        unused_upper_bits;

    assign new_mode       = decode_mode(loading);
    assign session_change = (new_mode != cur_mode);
    assign mem_byte       = din_valid & (state == STREAM_MEM);
    assign cfg_byte       = din_valid & (state == STREAM_CFG);
    assign base_full      = mode_base(new_mode, 32'(ROM_BASE), 32'(CARTRAM_BASE), 32'(BIOS_BASE));
    assign fifo_pop       = mem_ack & ~fifo_empty;

    // A byte on the mode-change cycle belongs to the old session, so an even-pointer
    // byte there is flushed immediately as a lone low half.
    always_comb begin
        push            = 1'b0;
        push_entry      = '0;
        push_entry.addr = ENTRY_ADDR_W'(ptr >> 1);
        if (mem_byte && ptr[0]) begin
            push            = 1'b1;
            push_entry.data = {din, low};
            push_entry.be   = 2'b11;
        end else if (mem_byte && session_change) begin
            push            = 1'b1;
            push_entry.data = {8'h00, din};
            push_entry.be   = 2'b01;
        end else if (session_change && state == STREAM_MEM && ptr[0]) begin
            push            = 1'b1;
            push_entry.data = {8'h00, low};
            push_entry.be   = 2'b01;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign mem_req  = ~fifo_empty;
    assign mem_addr = fifo_empty ? '0 : head.addr[ADDR_W-2:0];
    assign mem_din  = fifo_empty ? '0 : head.data;
    assign mem_be   = fifo_empty ? '0 : head.be;
    assign busy     = (state != IDLE) | ~fifo_empty;
    assign done     = busy_q & ~busy & mem_pend;

    assign unused_upper_bits = ^{head.addr[ENTRY_ADDR_W-1:ADDR_W-1], base_full[31:ADDR_W]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cur_mode     <= LOAD_IDLE;
            ptr          <= '0;
            low          <= '0;
            cfg_data     <= '0;
            loaded_bytes <= '0;
            overflow     <= 1'b0;
            busy_q       <= 1'b0;
            mem_pend     <= 1'b0;
        end else begin
            busy_q <= busy;
            if (done) mem_pend <= 1'b0;
            if (push && fifo_full && !fifo_pop) overflow <= 1'b1;
            if (mem_byte) begin
                if (!ptr[0]) low <= din;
                ptr          <= ptr + 1'b1;
                loaded_bytes <= loaded_bytes + 1'b1;
            end
            if (cfg_byte) begin
                cfg_data     <= {din, cfg_data[31:8]};
                loaded_bytes <= loaded_bytes + 1'b1;
            end
            if (session_change) begin
                cur_mode <= new_mode;
                if (new_mode != LOAD_IDLE) begin
                    ptr          <= base_full[ADDR_W-1:0];
                    low          <= '0;
                    loaded_bytes <= '0;
                    overflow     <= 1'b0;
                end
                case (new_mode)
                    LOAD_IDLE:   state <= IDLE;
                    LOAD_CONFIG: begin
                        state    <= STREAM_CFG;
                        cfg_data <= '0;
                    end
                    default: begin
                        state    <= STREAM_MEM;
                        mem_pend <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_romload_sdram_writer.sv
// Bench for romload_sdram_writer: directed session table, multi-cycle corner
// sequences and random sessions against an arithmetic write-list model.
module tb_romload_sdram_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  loading = '0;
    logic [7:0]  din = '0;
    logic        din_valid = 1'b0;
    logic        mem_ack = 1'b0;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic [15:0] mem_din;
    logic [1:0]  mem_be;
    logic [31:0] cfg_data;
    logic [24:0] loaded_bytes;
    logic        busy;
    logic        done;
    logic        overflow;

    romload_sdram_writer #(
        .ADDR_W       (25),
        .ROM_BASE     (25'h0),
        .CARTRAM_BASE (25'h1E00000),
        .BIOS_BASE    (25'h1F00000),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .loading      (loading),
        .din          (din),
        .din_valid    (din_valid),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_be       (mem_be),
        .mem_ack      (mem_ack),
        .cfg_data     (cfg_data),
        .loaded_bytes (loaded_bytes),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    typedef logic [41:0] wr_t;   // {addr[23:0], data[15:0], be[1:0]}

    int          errors = 0;
    int          checks = 0;
    wr_t         got[$];
    wr_t         exp_q[$];
    logic [7:0]  sess_bytes[$];
    int          done_cnt = 0;
    int          req_cnt = 0;
    bit          ack_en = 1'b0;
    int          ack_lat = 2;
    int          wait_cnt = 0;
    logic [31:0] model_cfg = '0;

    // Arbiter stand-in: acks the presented head after ack_lat waiting cycles.
    always begin
        @(posedge clk); #2;
        if (reset || !ack_en) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req) begin
            if (wait_cnt >= ack_lat) begin
                got.push_back({mem_addr, mem_din, mem_be});
                mem_ack  = 1'b1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end
    end

    always begin
        @(posedge clk); #3;
        if (done)    done_cnt++;
        if (mem_req) req_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        check({name, " drain busy"}, 64'(busy), 64'd0);
        tick();
    endtask

    task automatic send_queue();
        foreach (sess_bytes[i]) begin
            din       = sess_bytes[i];
            din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0;
        din       = '0;
    endtask

    task automatic run_session(input logic [2:0] mode, input string name);
        got.delete();
        loading = mode;
        tick();
        send_queue();
        loading = '0;
        tick();
        drain(name);
    endtask

    task automatic check_writes(input string name);
        check({name, " write count"}, 64'(got.size()), 64'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < got.size()) check($sformatf("%s write %0d", name, i), 64'(got[i]), 64'(exp_q[i]));
        end
    endtask

    // Expected writes from the pairing rule: word k holds bytes 2k, 2k+1 at base/2 + k.
    task automatic model_mem(input logic [23:0] base_hw);
        exp_q.delete();
        for (int k = 0; 2 * k < sess_bytes.size(); k++) begin
            logic [23:0] a;
            logic [7:0]  hi;
            logic [1:0]  be;
            a  = base_hw + 24'(k);
            hi = (2 * k + 1 < sess_bytes.size()) ? sess_bytes[2 * k + 1] : 8'h00;
            be = (2 * k + 1 < sess_bytes.size()) ? 2'b11 : 2'b01;
            exp_q.push_back({a, hi, sess_bytes[2 * k], be});
        end
    endtask

    typedef struct {
        logic [2:0]  mode;
        int          n;
        logic [63:0] bytes;
        int          exp_loaded;
        int          exp_words;
        wr_t         exp_first;
        wr_t         exp_last;
        logic [31:0] exp_cfg;
        int          exp_done;
    } vec_t;

    vec_t vt[5];

    initial begin
        vt[0] = '{3'd1, 4, 64'h44332211, 4, 2, {24'h000000, 16'h2211, 2'b11},
                  {24'h000001, 16'h4433, 2'b11}, 32'h0, 1};
        vt[1] = '{3'd4, 3, 64'hCCBBAA, 3, 2, {24'hF80000, 16'hBBAA, 2'b11},
                  {24'hF80001, 16'h00CC, 2'b01}, 32'h0, 1};
        vt[2] = '{3'd3, 5, 64'h0504030201, 5, 0, '0, '0, 32'h05040302, 0};
        vt[3] = '{3'd2, 1, 64'h5A, 1, 1, {24'hF00000, 16'h005A, 2'b01},
                  {24'hF00000, 16'h005A, 2'b01}, 32'h05040302, 1};
        vt[4] = '{3'd6, 2, 64'h8877, 1, 0, '0, '0, 32'h05040302, 0};

        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset mem_req", 64'(mem_req), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset overflow", 64'(overflow), 64'd0);
        check("reset loaded_bytes", 64'(loaded_bytes), 64'd0);
        check("reset cfg_data", 64'(cfg_data), 64'd0);
        check("reset mem_outs", 64'({mem_addr, mem_din, mem_be}), 64'd0);

        ack_en  = 1'b1;
        ack_lat = 2;
        for (int v = 0; v < 5; v++) begin
            int d0;
            int r0;
            string nm;
            nm = $sformatf("vec%0d", v);
            sess_bytes.delete();
            for (int i = 0; i < vt[v].n; i++) sess_bytes.push_back(vt[v].bytes[8 * i +: 8]);
            d0 = done_cnt;
            r0 = req_cnt;
            run_session(vt[v].mode, nm);
            check({nm, " loaded_bytes"}, 64'(loaded_bytes), 64'(vt[v].exp_loaded));
            check({nm, " write count"}, 64'(got.size()), 64'(vt[v].exp_words));
            if (vt[v].exp_words > 0 && got.size() > 0) begin
                check({nm, " first write"}, 64'(got[0]), 64'(vt[v].exp_first));
                check({nm, " last write"}, 64'(got[got.size() - 1]), 64'(vt[v].exp_last));
            end
            check({nm, " mem_req seen"}, 64'(req_cnt > r0), 64'(vt[v].exp_words > 0));
            check({nm, " cfg_data"}, 64'(cfg_data), 64'(vt[v].exp_cfg));
            check({nm, " done pulses"}, 64'(done_cnt - d0), 64'(vt[v].exp_done));
            check({nm, " overflow"}, 64'(overflow), 64'd0);
        end

        // Overflow: 40 bytes with ack withheld keep only the first 8 words.
        got.delete();
        ack_en  = 1'b0;
        loading = 3'd1;
        tick();
        sess_bytes.delete();
        for (int i = 0; i < 40; i++) sess_bytes.push_back(8'(i + 1));
        send_queue();
        check("ovf overflow set", 64'(overflow), 64'd1);
        check("ovf head held", 64'({mem_req, mem_addr, mem_din, mem_be}),
              64'({1'b1, 24'h0, 16'h0201, 2'b11}));
        check("ovf loaded_bytes", 64'(loaded_bytes), 64'd40);
        loading = '0;
        tick();
        ack_en  = 1'b1;
        ack_lat = 1;
        drain("ovf");
        exp_q.delete();
        for (int k = 0; k < 8; k++) exp_q.push_back({24'(k), 8'(2 * k + 2), 8'(2 * k + 1), 2'b11});
        check_writes("ovf");
        loading = 3'd1;
        tick();
        check("ovf cleared by new session", 64'(overflow), 64'd0);
        loading = '0;
        tick();
        drain("ovf empty session");

        // Mode change with words queued, plus a byte on the change cycle.
        got.delete();
        ack_en  = 1'b0;
        loading = 3'd1;
        tick();
        sess_bytes = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        send_queue();
        loading   = 3'd2;
        din       = 8'h16;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        check("chg loaded restart", 64'(loaded_bytes), 64'd0);
        sess_bytes = '{8'hC1, 8'hC2};
        send_queue();
        loading = '0;
        tick();
        check("chg loaded_bytes", 64'(loaded_bytes), 64'd2);
        ack_en = 1'b1;
        drain("chg");
        exp_q = '{{24'h000000, 16'h1110, 2'b11}, {24'h000001, 16'h1312, 2'b11},
                  {24'h000002, 16'h1514, 2'b11}, {24'h000003, 16'h0016, 2'b01},
                  {24'hF00000, 16'hC2C1, 2'b11}};
        check_writes("chg");

        // Reset while a write request is outstanding.
        got.delete();
        ack_en  = 1'b0;
        loading = 3'd1;
        tick();
        sess_bytes = '{8'hE1, 8'hE2};
        send_queue();
        check("rst pre mem_req", 64'(mem_req), 64'd1);
        reset   = 1'b1;
        loading = '0;
        tick();
        check("rst mem_req", 64'(mem_req), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst loaded_bytes", 64'(loaded_bytes), 64'd0);
        check("rst cfg_data", 64'(cfg_data), 64'd0);
        reset = 1'b0;
        tick();
        model_cfg = '0;

        // Random sessions against the model.
        ack_en = 1'b1;
        for (int r = 0; r < 10; r++) begin
            logic [2:0] mode;
            int         n;
            int         d0;
            string      nm;
            nm   = $sformatf("rnd%0d", r);
            mode = 3'($urandom_range(1, 4));
            n    = $urandom_range(0, 16);
            ack_lat = $urandom_range(0, 3);
            sess_bytes.delete();
            for (int i = 0; i < n; i++) sess_bytes.push_back(8'($urandom));
            d0 = done_cnt;
            run_session(mode, nm);
            if (mode == 3'd3) begin
                model_cfg = '0;
                foreach (sess_bytes[i]) model_cfg = {sess_bytes[i], model_cfg[31:8]};
                exp_q.delete();
            end else begin
                model_mem(mode == 3'd1 ? 24'h000000 : (mode == 3'd2 ? 24'hF00000 : 24'hF80000));
            end
            check_writes(nm);
            check({nm, " loaded_bytes"}, 64'(loaded_bytes), 64'(n));
            check({nm, " cfg_data"}, 64'(cfg_data), 64'(model_cfg));
            check({nm, " done pulses"}, 64'(done_cnt - d0), 64'(mode != 3'd3));
            check({nm, " overflow"}, 64'(overflow), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
